spi_counter_tx_ctrl: RTL and testbench
======================================

// Module: spi_counter_tx_ctrl
// PURPOSE
//  Sequences the SPI master that ships the up-counter state to the remote display board.
//  - On each send request: snapshots the count and the run/clear status.
//  - Frames them as two bytes, drives chip-select, issues byte starts to the SPI master
//    core and waits for its done pulses.
//  - Sits between the run/stop/clear control unit plus counter datapath and the SPI master.
// PARAMETERS
//  SETUP_CYC  2      clk cycles cs_n low before first byte start (1..255)
//  HOLD_CYC   2      clk cycles after last done before cs_n released (1..255)
//  TIMEOUT    1024   max clk cycles waiting for one i_done before abort (>=16)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  i_send_req   in   1   1-cycle request to transmit a frame (e.g. 10 ms tick)
//  i_runstop    in   1   run status from control unit (1=running)
//  i_clear      in   1   clear pulse from control unit
//  i_count      in   14  current counter value
//  o_start      out  1   1-cycle byte start to SPI master
//  o_tx_data    out  8   byte to SPI master, stable from o_start until i_done
//  i_done       in   1   1-cycle byte-complete pulse from SPI master
//  o_cs_n       out  1   slave chip-select, active low
//  o_busy       out  1   frame in progress (state != IDLE)
//  o_frame_done out  1   1-cycle pulse: frame completed normally
//  o_err        out  1   1-cycle pulse: frame aborted on timeout
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, o_cs_n=1, all other outputs 0, pending=0,
//    clr_flag=0, snapshot=0.
//  - Frame layout:
//    - byte0 = {run_s, clr_s, cnt_s[13:8]}
//    - byte1 = cnt_s[7:0]
//    - *_s are registers loaded in the cycle IDLE exits.
//  - clr_flag:
//    - Set by i_clear in any state.
//    - Copied to clr_s at snapshot.
//    - Cleared on o_frame_done only if no new i_clear arrived during that frame.
//    - An i_clear in the same cycle as frame completion wins (flag stays 1).
//  - pending:
//    - Set by i_send_req while o_busy=1; at most one pending request, extras dropped.
//    - IDLE treats pending like i_send_req, then clears it.
//  - States and transitions (all outputs registered):
//    - IDLE: on req|pending -> SETUP; snapshot; o_cs_n=0 next cycle.
//    - SETUP: wait SETUP_CYC cycles -> SEND0.
//    - SEND0: o_start=1 one cycle, o_tx_data=byte0 -> WAIT0.
//    - WAIT0: on i_done -> SEND1.
//    - SEND1: o_start=1, o_tx_data=byte1 -> WAIT1.
//    - WAIT1: on i_done -> HOLD.
//    - HOLD: wait HOLD_CYC cycles; then o_cs_n=1, o_frame_done=1 -> IDLE.
//  - Latency: req at cycle N -> o_cs_n=0 at N+1; first o_start at N+1+SETUP_CYC.
//  - i_done outside WAIT0/WAIT1 is ignored.
//  - Timeout: a 10-bit+ counter runs in WAIT0/WAIT1 and resets on entry. On reaching
//    TIMEOUT: o_cs_n=1, o_err=1 -> IDLE. clr_flag is kept and pending is kept.
//  - IDLE takes a new frame at earliest 1 cycle after o_frame_done/o_err (cs_n high >= 1 cycle).
//  - Snapshot is frozen for the frame; i_count/i_runstop changes mid-frame do not alter bytes.
//  - Reset mid-frame: immediate IDLE, o_cs_n=1, o_start=0; no done/err pulse.
// TESTING
//  1. req with count=0x1234, run=1, no clear, i_done 8 cycles after each start ->
//     bytes 0x92,0x34; cs_n low to frame_done = SETUP+HOLD+2 starts+waits; one frame_done.
//  2. i_clear pulse then req, count=0 -> byte0=0x40; next frame (no clear) byte0=0x00.
//  3. Three reqs during busy frame -> exactly one extra frame follows, cs_n high >=1 cycle
//     between frames.
//  4. Withhold i_done after SEND1 -> o_err after TIMEOUT cycles, cs_n=1, no frame_done;
//     clr_flag preserved.
//  5. Change i_count to 0x3FFF after SEND0 of a count=0x0001 frame -> byte1 still 0x01.
//  6. Assert reset low during WAIT0 -> cs_n=1, busy=0 asynchronously; next req sends a
//     clean frame.

Source files
------------

// File: rtl/spi_counter_tx_ctrl.sv
// Frames the counter snapshot into two SPI bytes, drives chip-select and sequences
// byte starts to the SPI master core, with timeout abort while waiting for byte completion.
module spi_counter_tx_ctrl #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_send_req,
  input  logic        i_runstop,
  input  logic        i_clear,
  input  logic [13:0] i_count,
  output logic        o_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_done,
  output logic        o_cs_n,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int unsigned CW = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1,
    HOLD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pending, pending_nx;
  logic          clr_flag, clr_flag_nx;
  logic          clr_seen, clr_seen_nx;
  logic          run_s, run_s_nx;
  logic          clr_s, clr_s_nx;
  logic [13:0]   cnt_s, cnt_s_nx;
  logic          start_nx;
  logic [7:0]    tx_nx;
  logic          cs_n_nx;
  logic          busy_nx;
  logic          frame_done_nx;
  logic          err_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= 1'b0;
      clr_flag     <= 1'b0;
      clr_seen     <= 1'b0;
      run_s        <= 1'b0;
      clr_s        <= 1'b0;
      cnt_s        <= '0;
      o_start      <= 1'b0;
      o_tx_data    <= '0;
      o_cs_n       <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pending      <= pending_nx;
      clr_flag     <= clr_flag_nx;
      clr_seen     <= clr_seen_nx;
      run_s        <= run_s_nx;
      clr_s        <= clr_s_nx;
      cnt_s        <= cnt_s_nx;
      o_start      <= start_nx;
      o_tx_data    <= tx_nx;
      o_cs_n       <= cs_n_nx;
      o_busy       <= busy_nx;
      o_frame_done <= frame_done_nx;
      o_err        <= err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    pending_nx    = pending | (i_send_req & (state != IDLE));
    clr_flag_nx   = clr_flag | i_clear;
    // clr_seen tracks clears arriving after the snapshot, which must survive frame completion
    clr_seen_nx   = clr_seen | (i_clear & (state != IDLE));
    run_s_nx      = run_s;
    clr_s_nx      = clr_s;
    cnt_s_nx      = cnt_s;
    start_nx      = 1'b0;
    tx_nx         = o_tx_data;
    cs_n_nx       = o_cs_n;
    frame_done_nx = 1'b0;
    err_nx        = 1'b0;

    case (state)
      IDLE: begin
        cs_n_nx = 1'b1;
        if (i_send_req || pending) begin
          state_nx    = SETUP;
          cnt_nx      = '0;
          pending_nx  = 1'b0;
          run_s_nx    = i_runstop;
          clr_s_nx    = clr_flag | i_clear;
          cnt_s_nx    = i_count;
          clr_seen_nx = 1'b0;
          cs_n_nx     = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = SEND0;
          start_nx = 1'b1;
          tx_nx    = {run_s, clr_s, cnt_s[13:8]};
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SEND0: begin
        state_nx = WAIT0;
        cnt_nx   = '0;
      end
      WAIT0: begin
        if (i_done) begin
          state_nx = SEND1;
          start_nx = 1'b1;
          tx_nx    = cnt_s[7:0];
        end else if (cnt == TO_LAST) begin
          state_nx = IDLE;
          cs_n_nx  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SEND1: begin
        state_nx = WAIT1;
        cnt_nx   = '0;
      end
      WAIT1: begin
        if (i_done) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else if (cnt == TO_LAST) begin
          state_nx = IDLE;
          cs_n_nx  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx      = IDLE;
          cs_n_nx       = 1'b1;
          frame_done_nx = 1'b1;
          // A clear in this very cycle also keeps the flag set
          if (!clr_seen && !i_clear) clr_flag_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cs_n_nx  = 1'b1;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_spi_counter_tx_ctrl.sv
// Bench for spi_counter_tx_ctrl: event-time reference model, directed frames with literal
// expectations, then randomized requests/clears/done responses.
module tb_spi_counter_tx_ctrl;

  localparam int unsigned SETUP = 3;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned TMO   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        runstop = 1'b0;
  logic        clear = 1'b0;
  logic        done = 1'b0;
  logic [13:0] count = '0;
  logic        start;
  logic [7:0]  tx;
  logic        cs_n, busy, fdone, err;

  always #5 clk = ~clk;

  spi_counter_tx_ctrl #(
    .SETUP_CYC(SETUP),
    .HOLD_CYC (HOLD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_send_req  (req),
    .i_runstop   (runstop),
    .i_clear     (clear),
    .i_count     (count),
    .o_start     (start),
    .o_tx_data   (tx),
    .i_done      (done),
    .o_cs_n      (cs_n),
    .o_busy      (busy),
    .o_frame_done(fdone),
    .o_err       (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // reference model: frame described by its event times
  bit         m_active = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_fd = 1'b0;
  bit         m_err = 1'b0;
  int         m_acc, m_s0, m_d0, m_d1;
  logic [7:0] m_b0, m_b1;
  int         m_last_clr = -1000;
  int         m_clr_cut = 0;

  // stimulus / observation state
  bit  rst_drive = 1'b0;
  bit  rand_mode = 1'b0;
  int  dly_q[$];
  int  done_at = -1;
  logic [7:0] seen_q[$];
  int  fd_cnt, err_cnt, cs_low_cnt, hi_run, last_gap, gap_cnt;
  bit  seen_low;
  int  first_start_cyc, last_start_cyc, err_cyc, req_cyc;
  logic err_cs_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, t, act, exp);
    end
  endtask

  task automatic clear_obs();
    seen_q.delete();
    fd_cnt = 0; err_cnt = 0; cs_low_cnt = 0; hi_run = 0;
    last_gap = -1; gap_cnt = 0; seen_low = 1'b0;
    first_start_cyc = -1; last_start_cyc = -1; err_cyc = -1; err_cs_n = 1'bx;
  endtask

  task automatic step();
    bit exp_start;
    bit cb;
    int d;
    exp_start = m_active && (t == m_s0 || (m_d0 >= 0 && t == m_d0 + 1));
    chk("cs_n", cs_n, !m_active);
    chk("busy", busy, m_active);
    chk("start", start, exp_start);
    chk("frame_done", fdone, m_fd);
    chk("err", err, m_err);
    if (m_active && t >= m_s0 && (m_d0 < 0 || t <= m_d0))
      chk("tx_byte0", tx, m_b0);
    else if (m_active && m_d0 >= 0 && t > m_d0 && (m_d1 < 0 || t <= m_d1))
      chk("tx_byte1", tx, m_b1);

    if (start === 1'b1) begin
      if (seen_q.size() == 0) first_start_cyc = t;
      seen_q.push_back(tx);
      last_start_cyc = t;
      if (dly_q.size() > 0) d = dly_q.pop_front();
      else d = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
      done_at = (d == 0) ? -1 : t + d;
    end
    if (fdone === 1'b1) fd_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = t;
      err_cs_n = cs_n;
    end
    if (cs_n === 1'b0) begin
      cs_low_cnt++;
      if (seen_low && hi_run > 0) begin
        last_gap = hi_run;
        gap_cnt++;
      end
      hi_run = 0;
      seen_low = 1'b1;
    end else begin
      hi_run++;
    end

    if (reset === 1'b1 && !rst_drive) begin
      reset = 1'b0;
      #1;
      chk("rst_async_cs_n", cs_n, 1);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_start", start, 0);
    end else begin
      reset = rst_drive;
    end
    if (!reset) done_at = -1;

    done = (t == done_at) || (rand_mode && $urandom_range(49) == 0);

    // advance the model with this cycle's inputs
    m_fd = 1'b0;
    m_err = 1'b0;
    if (!reset) begin
      m_active = 1'b0;
      m_pend = 1'b0;
      m_last_clr = -1000;
      m_clr_cut = t + 1;
    end else begin
      if (clear) m_last_clr = t;
      if (m_active) begin
        if (req) m_pend = 1'b1;
        if (m_d0 < 0) begin
          if (t > m_s0 && done) m_d0 = t;
          else if (t == m_s0 + int'(TMO)) begin m_active = 1'b0; m_err = 1'b1; end
        end else if (m_d1 < 0) begin
          if (t > m_d0 + 1 && done) m_d1 = t;
          else if (t == m_d0 + 1 + int'(TMO)) begin m_active = 1'b0; m_err = 1'b1; end
        end else if (t == m_d1 + int'(HOLD)) begin
          m_active = 1'b0;
          m_fd = 1'b1;
          if (m_last_clr < m_acc + 1) m_clr_cut = t + 1;
        end
      end else if (req || m_pend) begin
        m_pend = 1'b0;
        m_active = 1'b1;
        m_acc = t;
        m_s0 = t + 1 + int'(SETUP);
        m_d0 = -1;
        m_d1 = -1;
        cb = (m_last_clr >= m_clr_cut);
        m_b0 = {runstop, cb, count[13:8]};
        m_b1 = count[7:0];
      end
    end

    @(negedge clk);
    t++;
    req = 1'b0;
    clear = 1'b0;
    done = 1'b0;
  endtask

  task automatic run_frames(input int n, input int max);
    int ev0;
    ev0 = fd_cnt + err_cnt;
    for (int i = 0; i < max; i++) begin
      if (fd_cnt + err_cnt >= ev0 + n) break;
      step();
    end
    chk("frame_wait_bound", fd_cnt + err_cnt - ev0, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rst_left;
    #1 reset = 1'b0;
    @(negedge clk);
    t = 0;
    clear_obs();
    rst_drive = 1'b0;
    repeat (3) step();
    chk("reset_tx_data", tx, 0);
    chk("reset_cs_n", cs_n, 1);
    rst_drive = 1'b1;
    repeat (2) step();

    // 1: basic frame, done 8 cycles after each start
    clear_obs();
    count = 14'h1234; runstop = 1'b1; dly_q = {8, 8};
    req = 1'b1; req_cyc = t;
    run_frames(1, 200);
    repeat (2) step();
    chk("t1_nbytes", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      chk("t1_byte0", seen_q[0], 8'h92);
      chk("t1_byte1", seen_q[1], 8'h34);
    end
    chk("t1_cs_low_len", cs_low_cnt, SETUP + HOLD + 18);
    chk("t1_first_start_lat", first_start_cyc - req_cyc, 1 + SETUP);
    chk("t1_frame_done_cnt", fd_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // 2: clear reported once, then dropped
    clear_obs();
    count = '0; runstop = 1'b0; clear = 1'b1; step(); step();
    dly_q = {3, 3}; req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    if (seen_q.size() >= 1) chk("t2_byte0_clr", seen_q[0], 8'h40);
    clear_obs();
    dly_q = {3, 3}; req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    if (seen_q.size() >= 1) chk("t2_byte0_noclr", seen_q[0], 8'h00);
    chk("t2_nbytes", seen_q.size(), 2);

    // 3: three requests while busy give exactly one extra frame
    clear_obs();
    count = 14'h0A5A; dly_q = {3, 3, 3, 3};
    req = 1'b1; step();
    repeat (3) begin req = 1'b1; step(); step(); end
    run_frames(2, 200);
    repeat (30) step();
    chk("t3_frame_done_cnt", fd_cnt, 2);
    chk("t3_gap_cnt", gap_cnt, 1);
    chk("t3_gap_ge1", (last_gap >= 1), 1'b1);

    // 4: byte1 done withheld -> timeout abort, clear flag kept
    clear_obs();
    clear = 1'b1; step();
    count = 14'h0155; runstop = 1'b1; dly_q = {5, 0};
    req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_frame_done_cnt", fd_cnt, 0);
    chk("t4_err_cs_n", err_cs_n, 1);
    chk("t4_err_latency", err_cyc - last_start_cyc, TMO + 1);
    if (seen_q.size() >= 1) chk("t4_byte0", seen_q[0], 8'hC1);
    clear_obs();
    dly_q = {2, 2}; req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    if (seen_q.size() >= 1) chk("t4_retry_byte0", seen_q[0], 8'hC1);
    chk("t4_retry_done", fd_cnt, 1);
    clear_obs();
    dly_q = {2, 2}; req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    if (seen_q.size() >= 1) chk("t4_after_byte0", seen_q[0], 8'h81);

    // 5: snapshot frozen against mid-frame input changes
    clear_obs();
    count = 14'h0001; runstop = 1'b0; dly_q = {6, 6};
    req = 1'b1; step();
    for (int i = 0; i < 20 && seen_q.size() == 0; i++) step();
    count = 14'h3FFF; runstop = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    chk("t5_nbytes", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      chk("t5_byte0", seen_q[0], 8'h00);
      chk("t5_byte1", seen_q[1], 8'h01);
    end

    // 6: reset during WAIT0
    clear_obs();
    count = 14'h0777; runstop = 1'b1; dly_q = {0};
    req = 1'b1; step();
    for (int i = 0; i < 20 && seen_q.size() == 0; i++) step();
    repeat (3) step();
    rst_drive = 1'b0; step();
    repeat (2) step();
    rst_drive = 1'b1; repeat (2) step();
    chk("t6_no_pulse_done", fd_cnt, 0);
    chk("t6_no_pulse_err", err_cnt, 0);
    clear_obs();
    count = 14'h0ABC; dly_q = {4, 4}; req = 1'b1;
    run_frames(1, 200);
    repeat (2) step();
    chk("t6_nbytes", seen_q.size(), 2);
    if (seen_q.size() >= 2) begin
      chk("t6_byte0", seen_q[0], 8'h8A);
      chk("t6_byte1", seen_q[1], 8'hBC);
    end
    chk("t6_frame_done", fd_cnt, 1);

    // randomized traffic
    dly_q.delete();
    rand_mode = 1'b1;
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      req = ($urandom_range(24) == 0);
      clear = ($urandom_range(39) == 0);
      if ($urandom_range(3) == 0) count = 14'($urandom);
      if ($urandom_range(49) == 0) runstop = ~runstop;
      if (rst_left == 0 && $urandom_range(1499) == 0) rst_left = 2;
      rst_drive = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      step();
    end
    rand_mode = 1'b0;
    rst_drive = 1'b1;
    repeat (120) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
